// File: rtl/tiled_matmul_engine.sv
// tiled_matmul_engine: ROW x COL output tile C = A * B with programmable K.
// Operands arrive over req/grant channels; results drain as a valid/ready stream.
module tiled_matmul_engine #(
  parameter int WIDTH     = 16,
  parameter int ROW       = 4,
  parameter int COL       = 4,
  parameter int KMAX      = 32,
  parameter int ACC_WIDTH = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [$clog2(KMAX+1)-1:0]    k_len,
  input  logic                         acc_mode,
  output logic                         req_in,
  input  logic                         grant_in,
  input  logic [ROW*WIDTH-1:0]         Data_in_a,
  output logic                         req_w,
  input  logic                         grant_w,
  input  logic [COL*WIDTH-1:0]         Data_in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         Data_out,
  output logic                         busy,
  output logic                         done
);

  localparam int KW = $clog2(KMAX + 1);
  localparam int N  = ROW * COL;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, FETCH, MAC, DRAIN} state_t;

  state_t state, state_n;

  logic [KW-1:0]        k_lat;
  logic [KW-1:0]        k_cnt;
  logic [KW-1:0]        k_clamp;
  logic [ROW*WIDTH-1:0] a_reg;
  logic [COL*WIDTH-1:0] b_reg;
  logic                 a_held, b_held;
  logic                 a_held_n, b_held_n;
  logic                 cap_a, cap_b;
  logic                 start, xfer, last;
  logic [IW-1:0]        idx;

  logic signed [ACC_WIDTH-1:0] acc  [N];
  logic signed [PW-1:0]        prod [N];

  // Handshake qualifiers and clamped inner dimension
  always_comb begin
    start    = (state == IDLE) && en;
    cap_a    = (state == FETCH) && req_in && grant_in;
    cap_b    = (state == FETCH) && req_w && grant_w;
    a_held_n = (state == FETCH) && (a_held || cap_a);
    b_held_n = (state == FETCH) && (b_held || cap_b);
    xfer     = out_valid && out_ready;
    last     = xfer && (idx == IW'(N - 1));
    k_clamp  = (k_len > KW'(KMAX)) ? KW'(KMAX) : k_len;
  end

  // Outer-product terms for every cell of the tile
  always_comb begin
    for (int r = 0; r < ROW; r++) begin
      for (int c = 0; c < COL; c++) begin
        prod[r*COL+c] = PW'($signed(a_reg[r*WIDTH +: WIDTH]))
                      * PW'($signed(b_reg[c*WIDTH +: WIDTH]));
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (en) state_n = (k_clamp == '0) ? DRAIN : FETCH;
      FETCH: if (a_held_n && b_held_n) state_n = MAC;
      MAC:   state_n = (k_cnt + KW'(1) == k_lat) ? DRAIN : FETCH;
      DRAIN: if (last) state_n = IDLE;
    endcase
  end

  // Stream and status outputs
  always_comb begin
    out_valid = (state == DRAIN);
    busy      = (state != IDLE);
    Data_out  = out_valid ? acc[idx] : '0;
  end

  // Counters, operand capture, registered requests and done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_lat  <= '0;
      k_cnt  <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      a_held <= 1'b0;
      b_held <= 1'b0;
      req_in <= 1'b0;
      req_w  <= 1'b0;
      idx    <= '0;
      done   <= 1'b0;
    end else begin
      a_held <= a_held_n;
      b_held <= b_held_n;
      req_in <= (state_n == FETCH) && !a_held_n;
      req_w  <= (state_n == FETCH) && !b_held_n;
      done   <= last;
      if (cap_a) a_reg <= Data_in_a;
      if (cap_b) b_reg <= Data_in_b;
      if (start) begin
        k_lat <= k_clamp;
        k_cnt <= '0;
        idx   <= '0;
      end else begin
        if (state == MAC) k_cnt <= k_cnt + KW'(1);
        if (xfer) idx <= last ? '0 : idx + IW'(1);
      end
    end
  end

  // Accumulators: cleared on a fresh start, summed on MAC, held otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else if (start && !acc_mode) begin
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else if (state == MAC) begin
      for (int i = 0; i < N; i++) acc[i] <= acc[i] + ACC_WIDTH'(prod[i]);
    end
  end

endmodule

// File: tb/tb_tiled_matmul_engine.sv
// tb_tiled_matmul_engine: table-driven tile runs plus reset/idle and abort sequences.
// Grants, backpressure and junk grants are driven per cycle from the vector record.
module tb_tiled_matmul_engine;

  localparam int WIDTH = 16;
  localparam int ROW = 4;
  localparam int COL = 4;
  localparam int KMAX = 32;
  localparam int ACC_WIDTH = 40;
  localparam int KW = $clog2(KMAX + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 en = 1'b0;
  logic [KW-1:0]        k_len = '0;
  logic                 acc_mode = 1'b0;
  logic                 req_in;
  logic                 grant_in = 1'b0;
  logic [ROW*WIDTH-1:0] Data_in_a = '0;
  logic                 req_w;
  logic                 grant_w = 1'b0;
  logic [COL*WIDTH-1:0] Data_in_b = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [ACC_WIDTH-1:0] Data_out;
  logic                 busy;
  logic                 done;

  tiled_matmul_engine #(
    .WIDTH(WIDTH), .ROW(ROW), .COL(COL),
    .KMAX(KMAX), .ACC_WIDTH(ACC_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .k_len(k_len),
    .acc_mode(acc_mode),
    .req_in(req_in), .grant_in(grant_in), .Data_in_a(Data_in_a),
    .req_w(req_w), .grant_w(grant_w), .Data_in_b(Data_in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .Data_out(Data_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KW-1:0]                   k;
    logic                            acc;
    logic [3:0]                      dly_a;
    logic [3:0]                      dly_b;
    logic                            bp;
    logic [3:0]                      abort;
    logic [3:0][ROW*WIDTH-1:0]       a;
    logic [3:0][COL*WIDTH-1:0]       b;
    logic [15:0][ACC_WIDTH-1:0]      exp;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint got, input longint want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic logic [63:0] pk(input int x0, input int x1,
                                     input int x2, input int x3);
    return {16'(x3), 16'(x2), 16'(x1), 16'(x0)};
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, " req_in"}, req_in, 0);
    chk({tag, " req_w"}, req_w, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " Data_out"}, $signed(Data_out), 0);
  endtask

  task automatic run_tile(input vec_t v, input string tag);
    int a_n = 0;
    int b_n = 0;
    int wa = 0;
    int wb = 0;
    int xfers = 0;
    int dones = 0;
    int cyc = 0;
    int t_req = -1;
    int t_val = -1;
    int fetches = 0;
    int k_eff;
    logic pa = 1'b0;
    logic pb = 1'b0;
    logic prev_req = 1'b0;
    logic prev_stall = 1'b0;
    logic [ACC_WIDTH-1:0] prev_d = '0;
    k_eff = (int'(v.k) > KMAX) ? KMAX : int'(v.k);
    @(negedge clk);
    en = 1'b1;
    k_len = v.k;
    acc_mode = v.acc;
    @(negedge clk);
    en = 1'b0;
    while (cyc < 2000) begin
      if (pa) chk({tag, " req_in drop"}, req_in, 0);
      if (pb) chk({tag, " req_w drop"}, req_w, 0);
      if (req_in && !prev_req) fetches++;
      prev_req = req_in;
      if (v.abort != 0 && fetches == int'(v.abort)) begin
        rst = 1'b0;
        #1;
        check_quiet({tag, " abort"});
        grant_in = 1'b0;
        grant_w = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end
      if (req_in && t_req < 0) t_req = cyc;
      if (out_valid && t_val < 0) t_val = cyc;
      if (prev_stall) chk({tag, " hold"}, $signed(Data_out), $signed(prev_d));
      if (done) begin
        dones++;
        chk({tag, " idle valid"}, out_valid, 0);
        chk({tag, " idle busy"}, busy, 0);
        break;
      end
      pa = 1'b0;
      pb = 1'b0;
      if (req_in) begin
        if (wa >= int'(v.dly_a)) begin
          grant_in = 1'b1;
          Data_in_a = v.a[a_n % 4];
          a_n++;
          pa = 1'b1;
          wa = 0;
        end else begin
          grant_in = 1'b0;
          wa++;
        end
      end else begin
        grant_in = 1'b1;
        Data_in_a = {ROW{16'h7777}};
      end
      if (req_w) begin
        if (wb >= int'(v.dly_b)) begin
          grant_w = 1'b1;
          Data_in_b = v.b[b_n % 4];
          b_n++;
          pb = 1'b1;
          wb = 0;
        end else begin
          grant_w = 1'b0;
          wb++;
        end
      end else begin
        grant_w = 1'b1;
        Data_in_b = {COL{16'h6666}};
      end
      out_ready = v.bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (out_valid && out_ready) begin
        if (xfers < 16)
          chk({tag, " data"}, $signed(Data_out), $signed(v.exp[xfers]));
        xfers++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = Data_out;
      @(negedge clk);
      cyc++;
    end
    grant_in = 1'b0;
    grant_w = 1'b0;
    out_ready = 1'b0;
    chk({tag, " done pulses"}, dones, 1);
    chk({tag, " transfers"}, xfers, 16);
    chk({tag, " A grants"}, a_n, k_eff);
    chk({tag, " B grants"}, b_n, k_eff);
    if (v.dly_a == 0 && v.dly_b == 0 && k_eff > 0)
      chk({tag, " latency"}, t_val - t_req, 2 * k_eff);
    @(negedge clk);
    chk({tag, " done width"}, done, 0);
  endtask

  vec_t tv[8];

  initial begin
    int a0[4];
    int b1[4];
    a0 = '{-1, 2, -3, 4};
    b1 = '{-5, 0, 5, 32767};
    for (int i = 0; i < 8; i++) tv[i] = '0;

    tv[0].k = 1;
    tv[0].a[0] = pk(1, 1, 1, 1);
    tv[0].b[0] = pk(1, 2, 3, 4);
    for (int j = 0; j < 16; j++) tv[0].exp[j] = 40'(j % 4 + 1);

    tv[1] = tv[0];
    tv[1].acc = 1'b1;
    for (int j = 0; j < 16; j++) tv[1].exp[j] = 40'(2 * (j % 4 + 1));

    tv[2] = tv[1];
    tv[2].k = 0;

    tv[3].k = 2;
    tv[3].dly_b = 3;
    tv[3].a[0] = pk(-1, 2, -3, 4);
    tv[3].a[1] = pk(1, 1, 1, 1);
    tv[3].b[0] = pk(2, 2, 2, 2);
    tv[3].b[1] = pk(-5, 0, 5, 32767);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        tv[3].exp[r*4+c] = 40'(a0[r] * 2 + b1[c]);

    tv[4].k = 1;
    tv[4].bp = 1'b1;
    tv[4].a[0] = pk(1, 2, 3, 4);
    tv[4].b[0] = pk(1, 10, 100, 1000);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        tv[4].exp[r*4+c] = 40'((r + 1) * (c == 0 ? 1 : c == 1 ? 10 : c == 2 ? 100 : 1000));

    tv[5].k = 40;
    for (int s = 0; s < 4; s++) begin
      tv[5].a[s] = pk(1, 1, 1, 1);
      tv[5].b[s] = pk(1, 1, 1, 1);
    end
    for (int j = 0; j < 16; j++) tv[5].exp[j] = 40'(32);

    tv[6] = tv[5];
    tv[6].k = 4;
    tv[6].abort = 3;

    tv[7] = tv[0];
    tv[7].acc = 1'b1;

    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle reqs", {req_in, req_w, busy, out_valid, done}, 0);
    end

    for (int i = 0; i < 8; i++) run_tile(tv[i], $sformatf("vec%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
